// File: rtl/lfsr_bist_gen.sv
// lfsr_bist_gen: burst-driven Fibonacci LFSR pattern generator for BIST.
// A start pulse launches a burst of 'len' steps; load seeds the register
// (all-zero seeds are replaced by DEFAULT_SEED and flagged), hold pauses a
// burst. wrap flags a step that returns the state to the period reference.
// Optional build macro LFSR_MISR_EN adds sig_in and folds it into every step,
// turning the register into a MISR for response compaction.
module lfsr_bist_gen #(
   parameter int               WIDTH        = 4,
   parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b1100,
   parameter int               CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             hold,
`ifdef LFSR_MISR_EN
   input  logic [WIDTH-1:0] sig_in,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_rev,
   output logic             serial_out,
   output logic             wrap,
   output logic             seed_err
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   fsm_t             fsm_q,      fsm_d;
   logic [WIDTH-1:0] state_q,    state_d;
   logic [WIDTH-1:0] ref_q,      ref_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             done_q,     done_d;
   logic             wrap_q,     wrap_d;
   logic             seed_err_q, seed_err_d;
   logic [WIDTH-1:0] step_val;

   // One Fibonacci shift: left shift, parity of tapped bits enters bit 0.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   // Candidate next state if this edge turns out to be a step.
   always_comb begin
`ifdef LFSR_MISR_EN
      step_val = lfsr_step(state_q) ^ sig_in;
`else
      step_val = lfsr_step(state_q);
`endif
   end

   // Next-state logic; priority is load, then start, then step.
   always_comb begin
      fsm_d      = fsm_q;
      state_d    = state_q;
      ref_d      = ref_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      wrap_d     = 1'b0;
      seed_err_d = seed_err_q;
      if (load) begin
         // A zero seed would lock the generator, so substitute the default.
         if (seed == '0) begin
            state_d    = DEFAULT_SEED;
            ref_d      = DEFAULT_SEED;
            seed_err_d = 1'b1;
         end else begin
            state_d    = seed;
            ref_d      = seed;
            seed_err_d = 1'b0;
         end
         fsm_d = IDLE;
         cnt_d = '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     fsm_d = RUN;
                     cnt_d = len;
                  end else begin
                     // Empty burst completes immediately without stepping.
                     done_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (!hold) begin
                  state_d = step_val;
                  cnt_d   = cnt_q - CNT_W'(1);
                  wrap_d  = (step_val == ref_q);
                  if (cnt_q == CNT_W'(1)) begin
                     fsm_d  = IDLE;
                     done_d = 1'b1;
                  end
               end
            end
            default: begin
               fsm_d = IDLE;
            end
         endcase
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q      <= IDLE;
         state_q    <= DEFAULT_SEED;
         ref_q      <= DEFAULT_SEED;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         wrap_q     <= 1'b0;
         seed_err_q <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         state_q    <= state_d;
         ref_q      <= ref_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         wrap_q     <= wrap_d;
         seed_err_q <= seed_err_d;
      end
   end

   // Bit-reversed view of the state register.
   always_comb begin
      q_rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         q_rev[i] = state_q[WIDTH-1-i];
      end
   end

   assign busy       = (fsm_q == RUN);
   assign done       = done_q;
   assign q          = state_q;
   assign serial_out = state_q[WIDTH-1];
   assign wrap       = wrap_q;
   assign seed_err   = seed_err_q;

endmodule
